// File: rtl/vermibus_router_pkg.sv
// Shared types and the address-prefix decoder for the vermibus router.
package vermibus_router_pkg;

  localparam int MAX_DEVICES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_UNMAPPED = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_code_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] index;
  } decode_t;

  // Prefixes arrive zero-extended to 32 bits per slot; the lowest matching index wins.
  function automatic decode_t decode_prefix(input logic [31:0] address,
                                            input logic [MAX_DEVICES*32-1:0] prefixes,
                                            input int num_devices,
                                            input int prefix_width);
    decode_t r;
    r = '0;
    for (int i = 0; i < MAX_DEVICES; i++) begin
      if (!r.hit && (i < num_devices) &&
          ((address >> (32 - prefix_width)) == prefixes[i*32 +: 32])) begin
        r.hit   = 1'b1;
        r.index = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vermibus_watchdog.sv
// Request-age counter; expire_o marks the last cycle a request may wait.
module vermibus_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/vermibus_router.sv
// N-device data-bus router: prefix decode, latched target, watchdog, error capture, IRQ merge.
module vermibus_router
  import vermibus_router_pkg::*;
#(
  parameter int                                NUM_DEVICES       = 4,
  parameter int                                PREFIX_WIDTH      = 8,
  parameter logic [NUM_DEVICES*PREFIX_WIDTH-1:0] DEVICE_PREFIXES = {8'h00, 8'h80, 8'h81, 8'h82},
  parameter int                                TIMEOUT_CYCLES    = 256,
  parameter logic [31:0]                       ERROR_RDATA       = 32'hDEADBEEF,
  parameter bit                                REGISTER_RESPONSE = 1'b0,
  parameter logic [NUM_DEVICES-1:0]            IRQ_MASK          = '1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      host_valid,
  input  logic [31:0]               host_address,
  input  logic [3:0]                host_wstrobe,
  input  logic [31:0]               host_wdata,
  output logic [31:0]               host_rdata,
  output logic                      host_ready,
  output logic                      host_irq,
  output logic [NUM_DEVICES-1:0]    dev_valid,
  output logic [31:0]               dev_address,
  output logic [3:0]                dev_wstrobe,
  output logic [31:0]               dev_wdata,
  input  logic [NUM_DEVICES*32-1:0] dev_rdata,
  input  logic [NUM_DEVICES-1:0]    dev_ready,
  input  logic [NUM_DEVICES-1:0]    dev_irq,
  output logic                      err_valid,
  output logic [1:0]                err_code,
  output logic [31:0]               err_address
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] rsp_q, rsp_d;
  logic        err_valid_q;
  err_code_e   err_code_q, err_code_d;
  logic [31:0] err_address_q;
  logic        err_set;
  logic        wd_clear, wd_enable, wd_expire;
  decode_t     dec;

  logic [MAX_DEVICES*32-1:0] prefixes_pad, rdata_pad;
  logic [MAX_DEVICES-1:0]    ready_pad, valid_pad;

  // Pad per-device vectors to the maximum so a 4-bit index is always in range.
  always_comb begin
    prefixes_pad = '0;
    rdata_pad    = '0;
    ready_pad    = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      prefixes_pad[i*32 +: 32] = 32'(DEVICE_PREFIXES[i*PREFIX_WIDTH +: PREFIX_WIDTH]);
    end
    rdata_pad[NUM_DEVICES*32-1:0] = dev_rdata;
    ready_pad[NUM_DEVICES-1:0]    = dev_ready;
  end

  assign dec = decode_prefix(host_address, prefixes_pad, NUM_DEVICES, PREFIX_WIDTH);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rsp_d      = rsp_q;
    valid_pad  = '0;
    host_ready = 1'b0;
    host_rdata = '0;
    wd_clear   = 1'b1;
    wd_enable  = 1'b0;
    err_set    = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (host_valid && dec.hit) begin
          idx_d                = dec.index;
          valid_pad[dec.index] = 1'b1;
          if (ready_pad[dec.index]) begin
            if (REGISTER_RESPONSE) begin
              rsp_d   = rdata_pad[dec.index*32 +: 32];
              state_d = ST_RESP;
            end else begin
              host_ready = 1'b1;
              host_rdata = rdata_pad[dec.index*32 +: 32];
            end
          end else begin
            wd_clear  = 1'b0;
            wd_enable = 1'b1;
            state_d   = ST_WAIT;
          end
        end else if (host_valid) begin
          host_ready = 1'b1;
          err_set    = 1'b1;
          err_code_d = ERR_UNMAPPED;
        end
      end
      ST_WAIT: begin
        if (!host_valid) begin
          state_d = ST_IDLE;
        end else if (ready_pad[idx_q]) begin
          // A ready in the expiry cycle still counts as a normal completion.
          valid_pad[idx_q] = 1'b1;
          if (REGISTER_RESPONSE) begin
            rsp_d   = rdata_pad[idx_q*32 +: 32];
            state_d = ST_RESP;
          end else begin
            host_ready = 1'b1;
            host_rdata = rdata_pad[idx_q*32 +: 32];
            state_d    = ST_IDLE;
          end
        end else if (wd_expire) begin
          err_set    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          if (REGISTER_RESPONSE) begin
            rsp_d   = ERROR_RDATA;
            state_d = ST_RESP;
          end else begin
            host_ready = 1'b1;
            host_rdata = ERROR_RDATA;
            state_d    = ST_IDLE;
          end
        end else begin
          valid_pad[idx_q] = 1'b1;
          wd_clear         = 1'b0;
          wd_enable        = 1'b1;
        end
      end
      ST_RESP: begin
        host_ready = 1'b1;
        host_rdata = rsp_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset must silence the combinational request/response paths without waiting for an edge.
    if (reset) begin
      valid_pad  = '0;
      host_ready = 1'b0;
      host_rdata = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      rsp_q         <= '0;
      err_valid_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      err_address_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rsp_q       <= rsp_d;
      err_valid_q <= err_set;
      err_code_q  <= err_code_d;
      if (err_set) begin
        err_address_q <= host_address;
      end
    end
  end

  vermibus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear_i (wd_clear),
    .enable_i(wd_enable),
    .expire_o(wd_expire)
  );

  assign dev_valid   = valid_pad[NUM_DEVICES-1:0];
  assign dev_address = host_address;
  assign dev_wstrobe = host_wstrobe;
  assign dev_wdata   = host_wdata;
  assign host_irq    = |(dev_irq & IRQ_MASK);
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign err_address = err_address_q;

endmodule

// File: tb/tb_vermibus_router.sv
// Directed bench: a combinational-response router and a registered-response router on shared stimulus.
module tb_vermibus_router;

  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_valid;
  logic [31:0]   host_address;
  logic [3:0]    host_wstrobe;
  logic [31:0]   host_wdata;
  logic [ND*32-1:0] dev_rdata;
  logic [ND-1:0] dev_ready;
  logic [ND-1:0] dev_irq;

  logic [31:0]   c_rdata, r_rdata;
  logic          c_ready, r_ready, c_irq, r_irq;
  logic [ND-1:0] c_dvalid, r_dvalid;
  logic [31:0]   c_daddr, r_daddr, c_dwdata, r_dwdata;
  logic [3:0]    c_dwstrb, r_dwstrb;
  logic          c_evalid, r_evalid;
  logic [1:0]    c_ecode, r_ecode;
  logic [31:0]   c_eaddr, r_eaddr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vermibus_router #(
    .NUM_DEVICES(ND), .PREFIX_WIDTH(8), .DEVICE_PREFIXES({8'h81, 8'h80, 8'h00}),
    .TIMEOUT_CYCLES(4), .ERROR_RDATA(32'hDEADBEEF), .REGISTER_RESPONSE(1'b0),
    .IRQ_MASK(3'b101)
  ) u_comb (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_address(host_address),
    .host_wstrobe(host_wstrobe), .host_wdata(host_wdata), .host_rdata(c_rdata),
    .host_ready(c_ready), .host_irq(c_irq), .dev_valid(c_dvalid), .dev_address(c_daddr),
    .dev_wstrobe(c_dwstrb), .dev_wdata(c_dwdata), .dev_rdata(dev_rdata),
    .dev_ready(dev_ready), .dev_irq(dev_irq), .err_valid(c_evalid), .err_code(c_ecode),
    .err_address(c_eaddr)
  );

  vermibus_router #(
    .NUM_DEVICES(ND), .PREFIX_WIDTH(8), .DEVICE_PREFIXES({8'h81, 8'h80, 8'h00}),
    .TIMEOUT_CYCLES(4), .ERROR_RDATA(32'hDEADBEEF), .REGISTER_RESPONSE(1'b1),
    .IRQ_MASK(3'b111)
  ) u_reg (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_address(host_address),
    .host_wstrobe(host_wstrobe), .host_wdata(host_wdata), .host_rdata(r_rdata),
    .host_ready(r_ready), .host_irq(r_irq), .dev_valid(r_dvalid), .dev_address(r_daddr),
    .dev_wstrobe(r_dwstrb), .dev_wdata(r_dwdata), .dev_rdata(dev_rdata),
    .dev_ready(dev_ready), .dev_irq(dev_irq), .err_valid(r_evalid), .err_code(r_ecode),
    .err_address(r_eaddr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set here belong to the new cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    host_valid = 1'b0;
    dev_ready  = '0;
    dev_rdata  = '0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    host_valid   = 1'b0;
    host_address = '0;
    host_wstrobe = '0;
    host_wdata   = '0;
    dev_rdata    = '0;
    dev_ready    = '0;
    dev_irq      = '0;
    #3;
    check("rst_dev_valid", 32'(c_dvalid), 32'h0);
    check("rst_host_ready", 32'(c_ready), 32'h0);
    check("rst_host_rdata", c_rdata, 32'h0);
    check("rst_err_valid", 32'(c_evalid), 32'h0);
    check("rst_err_code", 32'(c_ecode), 32'h0);
    check("rst_err_address", c_eaddr, 32'h0);
    do_reset();

    // Read device 1, ready in cycle 2.
    next_cycle();
    host_valid = 1'b1; host_address = 32'h80000004; host_wstrobe = 4'h0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        dev_ready = 3'b010;
        dev_rdata[32 +: 32] = 32'h00001234;
      end
      settle();
      check($sformatf("t1_dev_valid_c%0d", c), 32'(c_dvalid), 32'h2);
      check($sformatf("t1_host_ready_c%0d", c), 32'(c_ready), (c == 2) ? 32'h1 : 32'h0);
      check($sformatf("t1_err_valid_c%0d", c), 32'(c_evalid), 32'h0);
      if (c == 2) check("t1_rdata", c_rdata, 32'h00001234);
      next_cycle();
    end
    host_valid = 1'b0; dev_ready = '0;
    settle();
    check("t1_err_valid_after", 32'(c_evalid), 32'h0);
    check("t1_err_code_after", 32'(c_ecode), 32'h0);

    // Unmapped read.
    next_cycle();
    host_valid = 1'b1; host_address = 32'h40000000;
    settle();
    check("t2_dev_valid", 32'(c_dvalid), 32'h0);
    check("t2_host_ready", 32'(c_ready), 32'h1);
    check("t2_rdata", c_rdata, 32'h0);
    check("t2_err_valid_c0", 32'(c_evalid), 32'h0);
    next_cycle();
    host_valid = 1'b0;
    settle();
    check("t2_err_valid_c1", 32'(c_evalid), 32'h1);
    check("t2_err_code", 32'(c_ecode), 32'h1);
    check("t2_err_address", c_eaddr, 32'h40000000);
    next_cycle();
    settle();
    check("t2_err_valid_c2", 32'(c_evalid), 32'h0);
    check("t2_err_code_sticky", 32'(c_ecode), 32'h1);

    // Write to device 2 which never answers: timeout in cycle 3.
    next_cycle();
    host_valid = 1'b1; host_address = 32'h81000000; host_wstrobe = 4'hF;
    host_wdata = 32'hA5A55A5A;
    settle();
    check("t3_bcast_addr", c_daddr, 32'h81000000);
    check("t3_bcast_wstrobe", 32'(c_dwstrb), 32'hF);
    check("t3_bcast_wdata", c_dwdata, 32'hA5A55A5A);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) settle();
      check($sformatf("t3_dev_valid_c%0d", c), 32'(c_dvalid), (c == 3) ? 32'h0 : 32'h4);
      check($sformatf("t3_host_ready_c%0d", c), 32'(c_ready), (c == 3) ? 32'h1 : 32'h0);
      if (c == 3) check("t3_rdata", c_rdata, 32'hDEADBEEF);
      next_cycle();
    end
    host_valid = 1'b0; host_wstrobe = 4'h0;
    settle();
    check("t3_err_valid", 32'(c_evalid), 32'h1);
    check("t3_err_code", 32'(c_ecode), 32'h2);
    check("t3_err_address", c_eaddr, 32'h81000000);

    // Device 0 ready exactly in the timeout cycle: response wins.
    next_cycle();
    host_valid = 1'b1; host_address = 32'h00000010;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        dev_ready = 3'b001;
        dev_rdata[0 +: 32] = 32'hCAFEF00D;
      end
      settle();
      check($sformatf("t4_host_ready_c%0d", c), 32'(c_ready), (c == 3) ? 32'h1 : 32'h0);
      if (c == 3) begin
        check("t4_rdata", c_rdata, 32'hCAFEF00D);
        check("t4_dev_valid_c3", 32'(c_dvalid), 32'h1);
      end
      next_cycle();
    end
    host_valid = 1'b0; dev_ready = '0;
    settle();
    check("t4_no_err_valid", 32'(c_evalid), 32'h0);
    check("t4_err_code_held", 32'(c_ecode), 32'h2);

    // Registered response: ready in cycle 1, host_ready in cycle 2 only.
    do_reset();
    next_cycle();
    host_valid = 1'b1; host_address = 32'h00000000;
    settle();
    check("t5_dev_valid_c0", 32'(r_dvalid), 32'h1);
    check("t5_host_ready_c0", 32'(r_ready), 32'h0);
    next_cycle();
    dev_ready = 3'b001; dev_rdata[0 +: 32] = 32'h5A5A0001;
    settle();
    check("t5_dev_valid_c1", 32'(r_dvalid), 32'h1);
    check("t5_host_ready_c1", 32'(r_ready), 32'h0);
    next_cycle();
    dev_ready = '0; dev_rdata = '0;
    settle();
    check("t5_host_ready_c2", 32'(r_ready), 32'h1);
    check("t5_dev_valid_c2", 32'(r_dvalid), 32'h0);
    check("t5_rdata_c2", r_rdata, 32'h5A5A0001);
    next_cycle();
    host_valid = 1'b0;
    settle();
    check("t5_host_ready_c3", 32'(r_ready), 32'h0);
    check("t5_err_valid", 32'(r_evalid), 32'h0);

    // Asynchronous reset in cycle 1 of a wait, then the held request restarts.
    do_reset();
    next_cycle();
    host_valid = 1'b1; host_address = 32'h80000000;
    next_cycle();
    settle();
    check("t6_dev_valid_c1", 32'(c_dvalid), 32'h2);
    reset = 1'b1;
    #1;
    check("t6_async_dev_valid", 32'(c_dvalid), 32'h0);
    check("t6_async_host_ready", 32'(c_ready), 32'h0);
    check("t6_async_reg_dev_valid", 32'(r_dvalid), 32'h0);
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      check($sformatf("t6_host_ready_c%0d", c), 32'(c_ready), (c == 3) ? 32'h1 : 32'h0);
      if (c == 0) check("t6_dev_valid_restart", 32'(c_dvalid), 32'h2);
      if (c == 3) check("t6_timeout_rdata", c_rdata, 32'hDEADBEEF);
      next_cycle();
    end
    host_valid = 1'b0;

    // IRQ merge with per-instance masks.
    dev_irq = 3'b010;
    settle();
    check("irq_masked", 32'(c_irq), 32'h0);
    check("irq_unmasked_reg", 32'(r_irq), 32'h1);
    dev_irq = 3'b100;
    #1;
    check("irq_enabled", 32'(c_irq), 32'h1);
    dev_irq = 3'b000;
    #1;
    check("irq_none", 32'(c_irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
